// File: rtl/top_memory_test_spec.sv
// Blockwise 4x4 integer transform engine: reads 8-bit pixels from MEM_IN,
// writes 16-bit coefficients to MEM_OUT, raises done after the last block.

module mem_in_8 #(
   parameter int AW = 14
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [AW-3:0]   wr_quad,
   input  logic [3:0][7:0] wr_data,
   input  logic [AW-3:0]   rd_quad,
   output logic [3:0][7:0] rd_data
);
   logic [7:0] array [0:(1<<AW)-1];

   // Preload-only port; the transform engine ties it off.
   always @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) array[{wr_quad, 2'(i)}] <= wr_data[i];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 4; i++) rd_data[i] = array[{rd_quad, 2'(i)}];
   end
endmodule

module mem_out_16 #(
   parameter int AW = 14
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-3:0]    wr_quad,
   input  logic [3:0][15:0] wr_data,
   input  logic [AW-3:0]    rd_quad,
   output logic [3:0][15:0] rd_data
);
   logic [15:0] array [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) array[{wr_quad, 2'(i)}] <= wr_data[i];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 4; i++) rd_data[i] = array[{rd_quad, 2'(i)}];
   end
endmodule

// state | meaning
// IDLE  | one cycle after reset release, counters cleared
// LOAD  | row r of the block: row transform into buffer row r
// STORE | output row u: column transform of buffer, write to MEM_OUT
// DONE  | all blocks written, done held high until reset
module top_memory_test_spec #(
   parameter int IMG_N = 128,
   parameter int BLK   = 4
) (
   input logic clk,
   input logic rstn
);
   localparam int NB  = IMG_N / BLK;
   localparam int NBL = $clog2(NB);
   localparam int BW  = 2 * NBL;
   localparam int AW  = $clog2(IMG_N * IMG_N);
   localparam int QW  = AW - 2;

   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

   state_t                  state_q, state_d;
   logic [BW-1:0]           block_q, block_d;
   logic [1:0]              row_q, row_d;
   logic signed [11:0]      buf_q [4][4];
   logic signed [11:0]      buf_d [4][4];
   logic                    we_q, we_d;
   logic [QW-1:0]           wq_q, wq_d;
   logic [3:0][15:0]        wdata_q, wdata_d;
   logic                    done, done_d;

   logic [QW-1:0]           quad_addr;
   logic [3:0][7:0]         rd_pix;
   logic [3:0][15:0]        out_rd_unused;
   logic signed [11:0]      p [4];
   logic signed [11:0]      z [4];
   logic signed [15:0]      b [4][4];
   logic signed [15:0]      y [4];

   // Pixel row and coefficient row share the same quad address layout.
   assign quad_addr = {block_q[BW-1:NBL], row_q, block_q[NBL-1:0]};

   mem_in_8 #(.AW(AW)) MEM_IN (
      .clk     (clk),
      .wr_en   (1'b0),
      .wr_quad ('0),
      .wr_data ('0),
      .rd_quad (quad_addr),
      .rd_data (rd_pix)
   );

   mem_out_16 #(.AW(AW)) MEM_OUT (
      .clk     (clk),
      .wr_en   (we_q),
      .wr_quad (wq_q),
      .wr_data (wdata_q),
      .rd_quad ('0),
      .rd_data (out_rd_unused)
   );

   always_comb begin
      for (int i = 0; i < 4; i++) p[i] = signed'({4'b0000, rd_pix[i]});
      z[0] = p[0] + p[1] + p[2] + p[3];
      z[1] = (p[0] <<< 1) + p[1] - p[2] - (p[3] <<< 1);
      z[2] = p[0] - p[1] - p[2] + p[3];
      z[3] = p[0] - (p[1] <<< 1) + (p[2] <<< 1) - p[3];
   end

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         for (int v = 0; v < 4; v++) b[r][v] = {{4{buf_q[r][v][11]}}, buf_q[r][v]};
      end
      for (int v = 0; v < 4; v++) begin
         y[v] = '0;
         case (row_q)
            2'd0: y[v] = b[0][v] + b[1][v] + b[2][v] + b[3][v];
            2'd1: y[v] = (b[0][v] <<< 1) + b[1][v] - b[2][v] - (b[3][v] <<< 1);
            2'd2: y[v] = b[0][v] - b[1][v] - b[2][v] + b[3][v];
            default: y[v] = b[0][v] - (b[1][v] <<< 1) + (b[2][v] <<< 1) - b[3][v];
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      block_d = block_q;
      row_d   = row_q;
      buf_d   = buf_q;
      we_d    = 1'b0;
      wq_d    = wq_q;
      wdata_d = wdata_q;
      done_d  = done;
      case (state_q)
         IDLE: begin
            state_d = LOAD;
            block_d = '0;
            row_d   = '0;
         end
         LOAD: begin
            for (int v = 0; v < 4; v++) buf_d[row_q][v] = z[v];
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) state_d = STORE;
         end
         STORE: begin
            we_d  = 1'b1;
            wq_d  = quad_addr;
            for (int v = 0; v < 4; v++) wdata_d[v] = y[v];
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
               if (block_q == '1) begin
                  state_d = DONE;
               end else begin
                  block_d = block_q + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         default: begin
            // The last row's write retires on the first DONE edge, so done
            // only rises once every coefficient is in MEM_OUT.
            done_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         block_q <= '0;
         row_q   <= '0;
         buf_q   <= '{default: '0};
         we_q    <= 1'b0;
         wq_q    <= '0;
         wdata_q <= '0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         block_q <= block_d;
         row_q   <= row_d;
         buf_q   <= buf_d;
         we_q    <= we_d;
         wq_q    <= wq_d;
         wdata_q <= wdata_d;
         done    <= done_d;
      end
   end
endmodule

// File: tb/tb_top_memory_test_spec.sv
// Bench for the 4x4 block transform engine: fixed-image vector table,
// random images against a matrix-product model, and a mid-run reset.

module tb_top_memory_test_spec;
   localparam int N     = 128;
   localparam int WORDS = N * N;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   always #5 clk = ~clk;

   top_memory_test_spec dut (
      .clk  (clk),
      .rstn (rstn)
   );

   typedef struct {
      int pat;
      int addr;
      int exp;
   } vec_t;

   vec_t        vecs [$];
   int          img [WORDS];
   logic [15:0] ref_y [WORDS];
   int          cm [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
   int          n_err = 0;
   int          n_chk = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input int p, input int a, input int e);
      vec_t v;
      v.pat  = p;
      v.addr = a;
      v.exp  = e;
      vecs.push_back(v);
   endtask

   task automatic load_pattern(input int p);
      for (int i = 0; i < WORDS; i++) begin
         case (p)
            0:       img[i] = 0;
            1:       img[i] = 255;
            2:       img[i] = (i == 0) ? 100 : 0;
            3:       img[i] = (i == 129) ? 255 : 0;
            default: img[i] = int'($urandom_range(0, 255));
         endcase
      end
   endtask

   // Y = C * X * C^T per block, straight from the matrix definition.
   task automatic build_model();
      for (int br = 0; br < N / 4; br++) begin
         for (int bc = 0; bc < N / 4; bc++) begin
            for (int u = 0; u < 4; u++) begin
               for (int v = 0; v < 4; v++) begin
                  int s;
                  s = 0;
                  for (int i = 0; i < 4; i++)
                     for (int j = 0; j < 4; j++)
                        s += cm[u][i] * img[(4 * br + i) * N + 4 * bc + j] * cm[v][j];
                  ref_y[(4 * br + u) * N + 4 * bc + v] = 16'(s);
               end
            end
         end
      end
   endtask

   task automatic start_run();
      rstn = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         dut.MEM_IN.array[i]  = 8'(img[i]);
         dut.MEM_OUT.array[i] = 16'hDEAD;
      end
      @(negedge clk);
      check("reset_done", int'(dut.done), 0);
      check("reset_we", int'(dut.we_q), 0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (dut.done !== 1'b1 && cyc < 9000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic check_latency(input string name, input int cyc);
      n_chk++;
      if (cyc < 8193 || cyc > 8200) begin
         n_err++;
         $display("FAIL %s: done after %0d cycles, required 8193..8200", name, cyc);
      end
   endtask

   task automatic compare_all(input string name);
      int mism;
      int first;
      mism  = 0;
      first = -1;
      for (int i = 0; i < WORDS; i++) begin
         if (dut.MEM_OUT.array[i] !== ref_y[i]) begin
            mism++;
            if (first < 0) first = i;
         end
      end
      check(name, mism, 0);
      if (first >= 0)
         $display("  first differing word %0d: got %h expected %h",
                  first, dut.MEM_OUT.array[first], ref_y[first]);
   endtask

   task automatic after_done_checks(input string name);
      repeat (20) @(posedge clk);
      #1;
      check({name, "_done_held"}, int'(dut.done), 1);
      check({name, "_no_write"}, int'(dut.we_q), 0);
   endtask

   initial begin
      int cyc;

      add_vec(0, 0, 0);
      add_vec(0, 8000, 0);
      add_vec(0, 16383, 0);
      add_vec(1, 0, 4080);
      add_vec(1, 1, 0);
      add_vec(1, 128, 0);
      add_vec(1, 4, 4080);
      add_vec(1, 512, 4080);
      add_vec(1, 15996, 4080);
      add_vec(1, 15997, 0);
      add_vec(2, 0, 100);
      add_vec(2, 1, 200);
      add_vec(2, 2, 100);
      add_vec(2, 129, 400);
      add_vec(2, 131, 200);
      add_vec(2, 387, 100);
      add_vec(2, 4, 0);
      add_vec(2, 512, 0);
      add_vec(3, 0, 255);
      add_vec(3, 129, 255);
      add_vec(3, 387, 1020);
      add_vec(3, 131, 16'hFE02);
      add_vec(3, 385, 16'hFE02);
      add_vec(3, 258, 255);

      #2;
      for (int p = 0; p < 4; p++) begin
         load_pattern(p);
         build_model();
         start_run();
         wait_done(cyc);
         check_latency($sformatf("p%0d_latency", p), cyc);
         foreach (vecs[k]) begin
            if (vecs[k].pat == p)
               check($sformatf("p%0d_addr%0d", p, vecs[k].addr),
                     int'(dut.MEM_OUT.array[vecs[k].addr]), vecs[k].exp);
         end
         compare_all($sformatf("p%0d_image", p));
      end

      load_pattern(4);
      build_model();
      start_run();
      wait_done(cyc);
      check_latency("rand_latency", cyc);
      compare_all("rand_image");
      after_done_checks("rand");
      compare_all("rand_image_after_done");

      // Reset mid-run: the rerun must rebuild every word from block 0.
      load_pattern(4);
      build_model();
      start_run();
      repeat (3000) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_done", int'(dut.done), 0);
      check("midrst_we", int'(dut.we_q), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      wait_done(cyc);
      check_latency("midrst_latency", cyc);
      compare_all("midrst_image");
      after_done_checks("midrst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/top_memory_test_spec.md
TOP_MEMORY_TEST_SPEC -- requirements
Module: top_memory_test

Interface
REQ-001: Parameter IMG_N, default 128, image width and height in pixels (square image, row-major, address = row*IMG_N + col).
REQ-002: Parameter BLK, default 4, transform block edge; fixed at 4, other values unsupported.
REQ-003: Port clk  input  1  single clock; all state updates on rising edge.
REQ-004: Port rstn  input  1  asynchronous active-low reset.
REQ-005: No other ports; results are observed hierarchically.
REQ-006: Instance MEM_IN SHALL contain reg array `array[0:16383]`, 8-bit unsigned pixels, preloaded externally, never written by the design.
REQ-007: Instance MEM_OUT SHALL contain reg array `array[0:16383]`, 16-bit two's-complement coefficients.
REQ-008: MEM_IN read port: 4 consecutive words at a 4-aligned address, combinational read.
REQ-009: MEM_OUT write port: 4 consecutive words at a 4-aligned address, written on the rising edge when the write enable is high.
REQ-010: Internal register `done`, 1 bit, high once all coefficients are written.

Function
REQ-011: Image partitioned into 32x32 non-overlapping 4x4 blocks, processed in raster order (block column fastest), blocks 0..1023.
REQ-012: Each block computes the integer transform Y = C*X*C^T with C rows [1,1,1,1], [2,1,-1,-2], [1,-1,-1,1], [1,-2,2,-1]; no scaling or rounding.
REQ-013: Row pass uses 12-bit signed intermediates; column pass produces 16-bit signed results (max |Y| = 9180, no overflow possible).
REQ-014: Y[u][v] of block (br,bc) written to MEM_OUT address (4*br+u)*128 + 4*bc + v.
REQ-015: FSM states: IDLE, LOAD, STORE, DONE.
REQ-016: IDLE: one cycle after reset release, then LOAD with block=0, row=0.
REQ-017: LOAD: 4 cycles; cycle r reads pixel row 4*br+r, applies the 1-D transform to that row and stores the 4 results in row r of a 4x4 buffer; after r=3, go to STORE.
REQ-018: STORE: 4 cycles; cycle u writes output row u (column transform of the buffer) to MEM_OUT; after u=3, go to LOAD of the next block, or to DONE after block 1023.
REQ-019: DONE: sets done=1, performs no further memory writes, remains until reset.
REQ-020: Throughput is 8 cycles per block; done SHALL be high within 8200 cycles of reset deassertion.
REQ-021: Block counter range is 0..1023; no wrap-around; terminal block transitions to DONE.

Reset
REQ-022: rstn low asynchronously forces state IDLE, block and row counters 0, 4x4 buffer 0, write enable 0, done 0.
REQ-023: Memory contents are not affected by reset.
REQ-024: Reset asserted mid-operation aborts the current block without a partial write in that cycle; processing restarts from block 0 after release, overwriting all outputs.

Verification
REQ-025: All-zero image -> all 16384 MEM_OUT words 0, done=1 by cycle 8200.
REQ-026: All pixels 255 -> every block has Y[0][0]=4080 (0000111111110000) at addresses (4br)*128+4bc, and all other words 0.
REQ-027: Single pixel 100 at address 0, rest 0 -> block 0 holds 100*[1,2,1,1]^T*[1,2,1,1] (Y00=100, Y01=200, Y11=400, Y33=100); all other blocks 0.
REQ-028: Pixel 255 at X[1][1] of block 0 -> Y[1][1]=255, Y[3][3]=1020, Y[1][3]=-510 (16'hFE02).
REQ-029: Random image -> every MEM_OUT word equals a software model of REQ-012/REQ-014, compared bit-exactly as 16-bit binary.
REQ-030: Assert rstn low at cycle 3000 for 2 cycles -> done stays 0 until the full rerun, final MEM_OUT matches the uninterrupted result, and done rises 8193 or more cycles after the second release.
